fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-side producer feeding the 16-bit instr bus of the decode/control stage.
- Generates the PC, issues single-outstanding requests to instruction memory (variable-latency req/ack), and buffers returned words in a DEPTH-entry FIFO.
- Presents words to decode with a valid/ready handshake.
- Handles control-transfer redirects from execute and stops fetching after a HALT (opcode 5'b00000).

Parameters:
RESET_PC, 16'h0000, PC loaded on reset
DEPTH, 2, instruction FIFO entries (power of 2, >=2)
NOP_INSTR, 16'h0800, word driven on instr when FIFO empty (opcode 5'b00001)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request; held until imem_ack
imem_addr  out  16  fetch address, stable while imem_req=1
imem_ack  in  1  response valid this cycle (may occur in the request's first cycle)
imem_data  in  16  instruction word, valid when imem_ack=1
instr  out  16  FIFO head word, or NOP_INSTR when empty
instr_pc  out  16  PC of head word (0 when empty)
pc_plus2  out  16  instr_pc+2 mod 2^16, used for the JAL/JALR link value
instr_valid  out  1  FIFO non-empty
instr_ready  in  1  decode accepts; pop on instr_valid&instr_ready
redirect  in  1  one-cycle pulse: flush and restart at redirect_pc
redirect_pc  in  16  target; bit 0 ignored (forced 0)
halted  out  1  HALT word consumed and fetch stopped

Behaviour:
- Reset (sync, rst=1 at posedge):
  - fetch_pc=RESET_PC, FIFO empty, state=RUN, outstanding=0, discard=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, instr=NOP_INSTR, instr_pc=0, instr_valid=0, halted=0.
  - Reset mid-request abandons it. A late ack is ignored only if it lands during reset; memory must not ack after reset deasserts for a pre-reset request.
- States:
  - RUN: fetching.
  - HALT_WAIT: HALT word received, draining FIFO.
  - HALTED: fetch stopped.
- Request issue (RUN only):
  - imem_req rises in the cycle after the registered condition (occupancy + outstanding) < DEPTH holds.
  - At most one request outstanding. imem_addr=fetch_pc.
  - Earliest request is the first cycle after rst deasserts.
- Ack with discard=0:
  - Push {imem_addr, imem_data}; fetch_pc += 2, wrapping 16'hFFFE -> 16'h0000.
  - imem_req deasserts the next cycle unless another request qualifies. Back-to-back: one request per 2 cycles minimum.
- HALT detect: a pushed word with [15:11]=5'b00000 moves the state to HALT_WAIT; no further requests are issued.
- HALT_WAIT -> HALTED when the HALT word is popped. halted=1 from the cycle after that pop.
- Pop on instr_valid&instr_ready.
  - Push and pop in the same cycle are both performed and occupancy is unchanged.
  - Overflow is impossible because of the issue gating.
- Redirect (any state, highest priority):
  - FIFO cleared the next cycle; fetch_pc=redirect_pc&16'hFFFE; state=RUN; halted=0.
  - If a request is outstanding and not acked this cycle: discard=1. imem_req stays high with the old address until ack, that data is dropped, then a request to the new PC is issued.
  - An ack in the same cycle as redirect is dropped.
  - A pop in the same cycle as redirect is harmless (FIFO flushed).
  - A second redirect while discard=1 updates fetch_pc only.
- instr/instr_pc/pc_plus2 are combinational from FIFO head; instr=NOP_INSTR when empty.
- instr_ready ignored when instr_valid=0.

Test Plan:
- Reset, mem ack latency 1, ready=1, words at 0x0000/0x0002/0x0004 = 0x4001/0xD800/0x0800 -> imem_addr sequence 0,2,4; instr matches in order; instr_pc 0,2,4; pc_plus2 2,4,6.
- ready=0 for 10 cycles, ack latency 0 -> exactly 2 words buffered; imem_req stays 0 while full; ready=1 drains in order with no loss or duplication.
- Word 0x0000 at 0x0006 -> no request after addr 6; halted=1 the cycle after the HALT word is popped; subsequent redirect to 0x0100 clears halted and fetches 0x0100.
- Redirect to 0x0041 while request to 0x0008 is pending (ack 3 cycles later) -> 0x0008 data not delivered; next imem_addr=0x0040; FIFO empty and instr=0x0800 in the interim.
- fetch_pc=0xFFFE -> after ack the next address is 0x0000; instr_pc=0xFFFE, pc_plus2=0x0000.
- rst asserted with 1 word buffered and a request pending -> next cycle instr_valid=0, imem_req=0; the following cycle imem_req=1, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, single-outstanding imem fetch and a DEPTH-entry
// instruction buffer presented to decode through a valid/ready handshake.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int unsigned DEPTH     = 2,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic [15:0] pc_plus2,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        halted
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {RUN, HALT_WAIT, HALTED} state_e;

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   pc_q, pc_d;
    logic          discard_q, discard_d;
    logic          halted_q, halted_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   data_q [DEPTH];
    logic [15:0]   tag_q  [DEPTH];
    logic          ack, push, pop;

    assign ack         = req_q & imem_ack;
    assign push        = ack & ~discard_q & ~redirect;
    assign instr_valid = (cnt_q != '0);
    assign pop         = instr_valid & instr_ready & ~redirect;
    assign instr       = instr_valid ? data_q[rd_q] : NOP_INSTR;
    assign instr_pc    = instr_valid ? tag_q[rd_q] : 16'h0000;
    assign pc_plus2    = instr_pc + 16'd2;
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign halted      = halted_q;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        if (push) begin
            wr_d = wr_q + PW'(1);
            pc_d = pc_q + 16'd2;
            if (imem_data[15:11] == 5'b00000) state_d = HALT_WAIT;
        end
        // Nothing is pushed after a HALT, so a HALT at the head is the last word
        if (pop) begin
            rd_d = rd_q + PW'(1);
            if (state_q == HALT_WAIT && instr[15:11] == 5'b00000)
                state_d = HALTED;
        end
        if (ack) discard_d = 1'b0;
        if (req_q) begin
            req_d = ~imem_ack;
        end else if (state_q == RUN && cnt_q < FULL && !redirect) begin
            req_d  = 1'b1;
            addr_d = pc_q;
        end
        // An in-flight request keeps its address; its data is dropped on arrival
        if (redirect) begin
            state_d   = RUN;
            pc_d      = redirect_pc & 16'hFFFE;
            wr_d      = '0;
            rd_d      = '0;
            cnt_d     = '0;
            discard_d = req_q & ~imem_ack;
        end
        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            req_q     <= 1'b0;
            addr_q    <= RESET_PC;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            halted_q  <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            halted_q  <= halted_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_q] <= imem_data;
            tag_q[wr_q]  <= addr_q;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: cycle vectors, corner sequences and a randomized run checked
// against a model of the instruction stream decode should observe.
module tb_fetch_unit;
    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;

    int n_chk = 0;
    int n_bad = 0;
    int lat = 1;
    int wcnt = 0;
    int acks = 0;
    bit halt_en = 0;
    logic [15:0] ovr [logic [15:0]];
    logic [31:0] popped [$];
    logic [15:0] ack_addrs [$];

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        req;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] ins;
        logic [15:0] pc;
        logic [15:0] p2;
        logic        hlt;
    } vec_t;
    vec_t tbl [11];

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .instr_pc(instr_pc), .pc_plus2(pc_plus2),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .halted(halted)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] memword(input logic [15:0] a);
        if (ovr.exists(a)) return ovr[a];
        if (halt_en && a[6:1] == 6'h2A) return {5'b00000, a[10:0]};
        return {a[15:11] | 5'b00001, a[10:0] ^ 11'h5A5};
    endfunction

    // memory: acks after lat waiting cycles of a held request
    initial begin
        imem_ack = 0;
        imem_data = 0;
        forever begin
            @(negedge clk);
            if (imem_req === 1'b1) begin
                if (wcnt >= lat) begin
                    imem_ack = 1;
                    imem_data = memword(imem_addr);
                    wcnt = 0;
                    acks++;
                    ack_addrs.push_back(imem_addr);
                end else begin
                    imem_ack = 0;
                    wcnt++;
                end
            end else begin
                imem_ack = 0;
                wcnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && instr_valid === 1'b1 && instr_ready && !redirect)
                popped.push_back({instr_pc, instr});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        redirect = 0;
        step();
        rst = 0;
        acks = 0;
        ack_addrs.delete();
        popped.delete();
    endtask

    initial begin
        logic [15:0] exp_pc;
        logic [15:0] w;
        logic [31:0] pw;
        bit halted_exp;
        bit found;
        bit prev;
        int npop;

        rst = 1;
        redirect = 0;
        redirect_pc = 0;
        instr_ready = 1;

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0800, 16'h0000, 16'h0002, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0800, 16'h0000, 16'h0002, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0800, 16'h0000, 16'h0002, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h4001, 16'h0000, 16'h0002, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0800, 16'h0000, 16'h0002, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0800, 16'h0000, 16'h0002, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 16'hD800, 16'h0002, 16'h0004, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 16'h0800, 16'h0000, 16'h0002, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 16'h0800, 16'h0000, 16'h0002, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'h0004, 1'b1, 16'h0800, 16'h0004, 16'h0006, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 16'h0006, 1'b0, 16'h0800, 16'h0000, 16'h0002, 1'b0};

        ovr[16'h0000] = 16'h4001;
        ovr[16'h0002] = 16'hD800;
        ovr[16'h0004] = 16'h0800;
        lat = 1;
        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst;
            instr_ready = tbl[i].rdy;
            step();
            chk($sformatf("v%0d_req", i), 16'(imem_req), 16'(tbl[i].req));
            chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("v%0d_valid", i), 16'(instr_valid), 16'(tbl[i].vld));
            chk($sformatf("v%0d_instr", i), instr, tbl[i].ins);
            chk($sformatf("v%0d_pc", i), instr_pc, tbl[i].pc);
            chk($sformatf("v%0d_p2", i), pc_plus2, tbl[i].p2);
            chk($sformatf("v%0d_halted", i), 16'(halted), 16'(tbl[i].hlt));
        end

        // ready low, zero-latency memory: buffer fills to two, then drains
        ovr.delete();
        lat = 0;
        instr_ready = 0;
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i >= 5) chk("full_noreq", 16'(imem_req), 16'd0);
        end
        chk("full_acks", 16'(acks), 16'd2);
        chk("full_valid", 16'(instr_valid), 16'd1);
        instr_ready = 1;
        popped.delete();
        for (int i = 0; i < 40 && popped.size() < 4; i++) step();
        chk("drain_cnt", 16'(popped.size() >= 4), 16'd1);
        for (int i = 0; i < 4 && i < popped.size(); i++) begin
            pw = popped[i];
            chk("drain_pc", pw[31:16], 16'(2 * i));
            chk("drain_word", pw[15:0], memword(16'(2 * i)));
        end

        // HALT at 0x0006
        ovr.delete();
        ovr[16'h0006] = 16'h0000;
        lat = 1;
        instr_ready = 1;
        do_reset();
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (popped.size() > 0) begin
                pw = popped[popped.size() - 1];
                if (pw[15:11] == 5'b00000) found = 1;
            end
            if (!found) chk("halt_early", 16'(halted), 16'd0);
        end
        chk("halt_found", 16'(found), 16'd1);
        chk("halt_set", 16'(halted), 16'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("halt_noreq", 16'(imem_req), 16'd0);
        end
        chk("halt_nacks", 16'(ack_addrs.size()), 16'd4);
        if (ack_addrs.size() > 0)
            chk("halt_last", ack_addrs[ack_addrs.size() - 1], 16'h0006);
        redirect = 1;
        redirect_pc = 16'h0100;
        step();
        redirect = 0;
        chk("halt_clear", 16'(halted), 16'd0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (imem_req) found = 1;
        end
        chk("halt_refetch", 16'(found), 16'd1);
        chk("halt_refaddr", imem_addr, 16'h0100);

        // redirect while the request to 0x0008 is pending
        ovr.delete();
        lat = 3;
        instr_ready = 1;
        do_reset();
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            step();
            if (imem_req && imem_addr == 16'h0008) found = 1;
        end
        chk("rd_pend", 16'(found), 16'd1);
        redirect = 1;
        redirect_pc = 16'h0041;
        popped.delete();
        step();
        redirect = 0;
        found = 0;
        prev = imem_req;
        for (int i = 0; i < 20 && !found; i++) begin
            chk("rd_empty", 16'(instr_valid), 16'd0);
            chk("rd_nop", instr, 16'h0800);
            step();
            if (imem_req && !prev) found = 1;
            else if (imem_req) chk("rd_hold", imem_addr, 16'h0008);
            prev = imem_req;
        end
        chk("rd_found", 16'(found), 16'd1);
        chk("rd_addr", imem_addr, 16'h0040);
        chk("rd_nopop", 16'(popped.size()), 16'd0);
        for (int i = 0; i < 20 && popped.size() == 0; i++) step();
        chk("rd_popped", 16'(popped.size() > 0), 16'd1);
        if (popped.size() > 0) begin
            pw = popped[0];
            chk("rd_first", pw[31:16], 16'h0040);
        end

        // PC wrap at 0xFFFE
        ovr.delete();
        lat = 1;
        instr_ready = 0;
        do_reset();
        redirect = 1;
        redirect_pc = 16'hFFFE;
        step();
        redirect = 0;
        for (int i = 0; i < 20 && !instr_valid; i++) step();
        chk("wrap_valid", 16'(instr_valid), 16'd1);
        chk("wrap_pc", instr_pc, 16'hFFFE);
        chk("wrap_p2", pc_plus2, 16'h0000);
        chk("wrap_word", instr, memword(16'hFFFE));
        for (int i = 0; i < 10 && !imem_req; i++) step();
        chk("wrap_req", 16'(imem_req), 16'd1);
        chk("wrap_addr", imem_addr, 16'h0000);

        // reset with one word buffered and a request pending
        lat = 2;
        instr_ready = 0;
        do_reset();
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (instr_valid && imem_req) found = 1;
        end
        chk("rst_setup", 16'(found), 16'd1);
        rst = 1;
        step();
        chk("rst_valid", 16'(instr_valid), 16'd0);
        chk("rst_req", 16'(imem_req), 16'd0);
        rst = 0;
        step();
        chk("rst_req2", 16'(imem_req), 16'd1);
        chk("rst_addr", imem_addr, 16'h0000);

        // randomized: decode must see a contiguous stream from each restart
        halt_en = 1;
        ovr.delete();
        do_reset();
        exp_pc = 16'h0000;
        halted_exp = 0;
        npop = 0;
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            lat = $urandom_range(0, 3);
            redirect = halted_exp ? ($urandom_range(0, 4) == 0)
                                  : ($urandom_range(0, 59) == 0);
            redirect_pc = ($urandom_range(0, 7) == 0)
                        ? 16'hFFF8 + 16'($urandom_range(0, 7))
                        : 16'($urandom);
            if (!redirect && instr_valid && instr_ready) begin
                w = memword(exp_pc);
                chk("rnd_pc", instr_pc, exp_pc);
                chk("rnd_word", instr, w);
                chk("rnd_p2", pc_plus2, exp_pc + 16'd2);
                if (w[15:11] == 5'b00000) halted_exp = 1;
                exp_pc = exp_pc + 16'd2;
                npop++;
            end
            if (redirect) begin
                exp_pc = redirect_pc & 16'hFFFE;
                halted_exp = 0;
            end
            step();
            chk("rnd_halted", 16'(halted), 16'(halted_exp));
            if (halted_exp) begin
                chk("rnd_idle", 16'(instr_valid), 16'd0);
                chk("rnd_noreq", 16'(imem_req), 16'd0);
            end
        end
        redirect = 0;
        chk("rnd_progress", 16'(npop > 100), 16'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
